// File: rtl/vga_mode_ctrl_pkg.sv
// Shared constants for the VGA mode controller: preset 60 Hz timings,
// config register map and FSM state encoding.
package vga_mode_ctrl_pkg;

    localparam int PRESET_COUNT = 4;

    // Per-mode totals and porches in pixels/lines; mode order 640x480,
    // 800x600, 1024x768, 1280x1024.
    localparam int H_TOTAL [PRESET_COUNT] = '{800, 1056, 1344, 1688};
    localparam int H_SYNC  [PRESET_COUNT] = '{96, 128, 136, 112};
    localparam int H_BP    [PRESET_COUNT] = '{48, 88, 160, 248};
    localparam int H_FP    [PRESET_COUNT] = '{16, 40, 24, 48};
    localparam int V_TOTAL [PRESET_COUNT] = '{525, 628, 806, 1066};
    localparam int V_SYNC  [PRESET_COUNT] = '{2, 4, 6, 3};
    localparam int V_BP    [PRESET_COUNT] = '{33, 23, 29, 38};
    localparam int V_FP    [PRESET_COUNT] = '{10, 1, 3, 1};

    localparam int ADDR_MODE_SEL   = 0;
    localparam int ADDR_CUST_HMAX  = 1;
    localparam int ADDR_CUST_HSYNC = 2;
    localparam int ADDR_CUST_HBP   = 3;
    localparam int ADDR_CUST_HFP   = 4;
    localparam int ADDR_CUST_VMAX  = 5;
    localparam int ADDR_CUST_VSYNC = 6;
    localparam int ADDR_CUST_VBP   = 7;
    localparam int ADDR_CUST_VFP   = 8;
    localparam int ADDR_ERR_CLR    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_t;

endpackage

// File: rtl/vga_mode_ctrl_if.sv
// Config write bus (Valid/Addr/Data) for the VGA mode controller.
interface vga_mode_ctrl_if #(
    parameter int CONFIG_WIDTH = 16
);
    logic                    Valid;
    logic [CONFIG_WIDTH-1:0] Addr;
    logic [CONFIG_WIDTH-1:0] Data;

    modport master (output Valid, Addr, Data);
    modport slave  (input  Valid, Addr, Data);
endinterface

// File: rtl/vga_mode_rom.sv
// Combinational mode lookup: preset table or custom fields, plus a flag
// saying whether the requested index/custom timing is usable.
module vga_mode_rom
    import vga_mode_ctrl_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int MODE_WIDTH    = 3,
    parameter int PULSE_WIDTH   = 8,
    parameter int REZ_MAX_WIDTH = 11,
    parameter int MARGIN_WIDTH  = 9
) (
    input  logic [MODE_WIDTH-1:0]    mode,
    input  logic [REZ_MAX_WIDTH-1:0] cust_hmax,
    input  logic [PULSE_WIDTH-1:0]   cust_hsync,
    input  logic [MARGIN_WIDTH-1:0]  cust_hbp,
    input  logic [MARGIN_WIDTH-1:0]  cust_hfp,
    input  logic [REZ_MAX_WIDTH-1:0] cust_vmax,
    input  logic [PULSE_WIDTH-1:0]   cust_vsync,
    input  logic [MARGIN_WIDTH-1:0]  cust_vbp,
    input  logic [MARGIN_WIDTH-1:0]  cust_vfp,
    output logic [REZ_MAX_WIDTH-1:0] hmax,
    output logic [PULSE_WIDTH-1:0]   hsync,
    output logic [MARGIN_WIDTH-1:0]  hbp,
    output logic [MARGIN_WIDTH-1:0]  hfp,
    output logic [REZ_MAX_WIDTH-1:0] vmax,
    output logic [PULSE_WIDTH-1:0]   vsync,
    output logic [MARGIN_WIDTH-1:0]  vbp,
    output logic [MARGIN_WIDTH-1:0]  vfp,
    output logic                     valid
);

    logic [1:0] sel;
    int         hsum;
    int         vsum;

    always_comb begin
        sel   = mode[1:0];
        hsum  = int'(cust_hsync) + int'(cust_hbp) + int'(cust_hfp);
        vsum  = int'(cust_vsync) + int'(cust_vbp) + int'(cust_vfp);
        hmax  = cust_hmax;
        hsync = cust_hsync;
        hbp   = cust_hbp;
        hfp   = cust_hfp;
        vmax  = cust_vmax;
        vsync = cust_vsync;
        vbp   = cust_vbp;
        vfp   = cust_vfp;
        valid = 1'b0;
        if (int'(mode) < NUM_MODES) begin
            hmax  = REZ_MAX_WIDTH'(H_TOTAL[sel] - 1);
            hsync = PULSE_WIDTH'(H_SYNC[sel]);
            hbp   = MARGIN_WIDTH'(H_BP[sel]);
            hfp   = MARGIN_WIDTH'(H_FP[sel]);
            vmax  = REZ_MAX_WIDTH'(V_TOTAL[sel] - 1);
            vsync = PULSE_WIDTH'(V_SYNC[sel]);
            vbp   = MARGIN_WIDTH'(V_BP[sel]);
            vfp   = MARGIN_WIDTH'(V_FP[sel]);
            valid = 1'b1;
        end else if (int'(mode) == NUM_MODES) begin
            // Blanking must leave at least one visible pixel/line.
            valid = (hsum < int'(cust_hmax)) && (vsum < int'(cust_vmax));
        end
    end

endmodule

// File: rtl/vga_mode_ctrl.sv
// VGA mode controller: stages a mode change and applies it on Frame_end.
// Optional VGA_CFG_IMMEDIATE_EN: Data MSB on a mode select applies at once.
module vga_mode_ctrl
    import vga_mode_ctrl_pkg::*;
#(
    parameter int CONFIG_WIDTH  = 16,
    parameter int NUM_MODES     = 4,
    parameter int MODE_WIDTH    = 3,
    parameter int DEFAULT_MODE  = 0,
    parameter int PULSE_WIDTH   = 8,
    parameter int REZ_MAX_WIDTH = 11,
    parameter int MARGIN_WIDTH  = 9
) (
    input  logic                     Clk,
    input  logic                     Rst,
    vga_mode_ctrl_if.slave           cfg,
    input  logic                     Frame_end,
    output logic                     Load_config,
    output logic                     Cfg_busy,
    output logic                     Cfg_err,
    output logic [MODE_WIDTH-1:0]    Mode_active,
    output logic [PULSE_WIDTH-1:0]   H_sync_pulse,
    output logic [PULSE_WIDTH-1:0]   V_sync_pulse,
    output logic [REZ_MAX_WIDTH-1:0] H_count_max,
    output logic [REZ_MAX_WIDTH-1:0] V_count_max,
    output logic [MARGIN_WIDTH-1:0]  H_left_margin,
    output logic [MARGIN_WIDTH-1:0]  V_left_margin,
    output logic [MARGIN_WIDTH-1:0]  H_right_margin,
    output logic [MARGIN_WIDTH-1:0]  V_right_margin
);

    state_t state, state_nx;

    logic [REZ_MAX_WIDTH-1:0] c_hmax, c_vmax, r_hmax, r_vmax;
    logic [REZ_MAX_WIDTH-1:0] p_hmax, p_vmax;
    logic [PULSE_WIDTH-1:0]   c_hsync, c_vsync, r_hsync, r_vsync;
    logic [PULSE_WIDTH-1:0]   p_hsync, p_vsync;
    logic [MARGIN_WIDTH-1:0]  c_hbp, c_hfp, c_vbp, c_vfp;
    logic [MARGIN_WIDTH-1:0]  r_hbp, r_hfp, r_vbp, r_vfp;
    logic [MARGIN_WIDTH-1:0]  p_hbp, p_hfp, p_vbp, p_vfp;
    logic [MODE_WIDTH-1:0]    p_idx, idx;
    logic                     r_valid;

    logic sel_wr, sel_ok, err_clr, imm;
    logic apply_pend, apply_imm;
    logic unused_bits;

    assign idx         = cfg.Data[MODE_WIDTH-1:0];
    assign unused_bits = ^cfg.Data;
    assign Cfg_busy    = (state != IDLE);

    vga_mode_rom #(
        .NUM_MODES    (NUM_MODES),
        .MODE_WIDTH   (MODE_WIDTH),
        .PULSE_WIDTH  (PULSE_WIDTH),
        .REZ_MAX_WIDTH(REZ_MAX_WIDTH),
        .MARGIN_WIDTH (MARGIN_WIDTH)
    ) u_rom (
        .mode      (idx),
        .cust_hmax (c_hmax),
        .cust_hsync(c_hsync),
        .cust_hbp  (c_hbp),
        .cust_hfp  (c_hfp),
        .cust_vmax (c_vmax),
        .cust_vsync(c_vsync),
        .cust_vbp  (c_vbp),
        .cust_vfp  (c_vfp),
        .hmax      (r_hmax),
        .hsync     (r_hsync),
        .hbp       (r_hbp),
        .hfp       (r_hfp),
        .vmax      (r_vmax),
        .vsync     (r_vsync),
        .vbp       (r_vbp),
        .vfp       (r_vfp),
        .valid     (r_valid)
    );

    always_comb begin
        sel_wr     = cfg.Valid &&
                     (cfg.Addr == CONFIG_WIDTH'(ADDR_MODE_SEL));
        sel_ok     = sel_wr && r_valid;
        err_clr    = cfg.Valid &&
                     (cfg.Addr == CONFIG_WIDTH'(ADDR_ERR_CLR));
`ifdef VGA_CFG_IMMEDIATE_EN
        imm        = cfg.Data[CONFIG_WIDTH-1];
`else
        imm        = 1'b0;
`endif
        state_nx   = state;
        apply_pend = 1'b0;
        apply_imm  = 1'b0;
        // An accepted mode select always outranks a coincident Frame_end.
        if (sel_ok) begin
            state_nx  = imm ? APPLY : PEND;
            apply_imm = imm;
        end else begin
            unique case (state)
                IDLE:  state_nx = IDLE;
                PEND: begin
                    if (Frame_end) begin
                        state_nx   = APPLY;
                        apply_pend = 1'b1;
                    end
                end
                APPLY: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Cfg_err <= 1'b0;
        end else if (sel_wr && !r_valid) begin
            Cfg_err <= 1'b1;
        end else if (err_clr) begin
            Cfg_err <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            c_hmax  <= REZ_MAX_WIDTH'(H_TOTAL[0] - 1);
            c_hsync <= PULSE_WIDTH'(H_SYNC[0]);
            c_hbp   <= MARGIN_WIDTH'(H_BP[0]);
            c_hfp   <= MARGIN_WIDTH'(H_FP[0]);
            c_vmax  <= REZ_MAX_WIDTH'(V_TOTAL[0] - 1);
            c_vsync <= PULSE_WIDTH'(V_SYNC[0]);
            c_vbp   <= MARGIN_WIDTH'(V_BP[0]);
            c_vfp   <= MARGIN_WIDTH'(V_FP[0]);
        end else if (cfg.Valid) begin
            if (cfg.Addr == CONFIG_WIDTH'(ADDR_CUST_HMAX))
                c_hmax <= cfg.Data[REZ_MAX_WIDTH-1:0];
            if (cfg.Addr == CONFIG_WIDTH'(ADDR_CUST_HSYNC))
                c_hsync <= cfg.Data[PULSE_WIDTH-1:0];
            if (cfg.Addr == CONFIG_WIDTH'(ADDR_CUST_HBP))
                c_hbp <= cfg.Data[MARGIN_WIDTH-1:0];
            if (cfg.Addr == CONFIG_WIDTH'(ADDR_CUST_HFP))
                c_hfp <= cfg.Data[MARGIN_WIDTH-1:0];
            if (cfg.Addr == CONFIG_WIDTH'(ADDR_CUST_VMAX))
                c_vmax <= cfg.Data[REZ_MAX_WIDTH-1:0];
            if (cfg.Addr == CONFIG_WIDTH'(ADDR_CUST_VSYNC))
                c_vsync <= cfg.Data[PULSE_WIDTH-1:0];
            if (cfg.Addr == CONFIG_WIDTH'(ADDR_CUST_VBP))
                c_vbp <= cfg.Data[MARGIN_WIDTH-1:0];
            if (cfg.Addr == CONFIG_WIDTH'(ADDR_CUST_VFP))
                c_vfp <= cfg.Data[MARGIN_WIDTH-1:0];
        end
    end

    // Pending snapshot: frozen at select time, immune to later custom writes.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            p_idx   <= MODE_WIDTH'(DEFAULT_MODE);
            p_hmax  <= REZ_MAX_WIDTH'(H_TOTAL[DEFAULT_MODE] - 1);
            p_hsync <= PULSE_WIDTH'(H_SYNC[DEFAULT_MODE]);
            p_hbp   <= MARGIN_WIDTH'(H_BP[DEFAULT_MODE]);
            p_hfp   <= MARGIN_WIDTH'(H_FP[DEFAULT_MODE]);
            p_vmax  <= REZ_MAX_WIDTH'(V_TOTAL[DEFAULT_MODE] - 1);
            p_vsync <= PULSE_WIDTH'(V_SYNC[DEFAULT_MODE]);
            p_vbp   <= MARGIN_WIDTH'(V_BP[DEFAULT_MODE]);
            p_vfp   <= MARGIN_WIDTH'(V_FP[DEFAULT_MODE]);
        end else if (sel_ok) begin
            p_idx   <= idx;
            p_hmax  <= r_hmax;
            p_hsync <= r_hsync;
            p_hbp   <= r_hbp;
            p_hfp   <= r_hfp;
            p_vmax  <= r_vmax;
            p_vsync <= r_vsync;
            p_vbp   <= r_vbp;
            p_vfp   <= r_vfp;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Load_config    <= 1'b1;
            Mode_active    <= MODE_WIDTH'(DEFAULT_MODE);
            H_count_max    <= REZ_MAX_WIDTH'(H_TOTAL[DEFAULT_MODE] - 1);
            H_sync_pulse   <= PULSE_WIDTH'(H_SYNC[DEFAULT_MODE]);
            H_left_margin  <= MARGIN_WIDTH'(H_BP[DEFAULT_MODE]);
            H_right_margin <= MARGIN_WIDTH'(H_FP[DEFAULT_MODE]);
            V_count_max    <= REZ_MAX_WIDTH'(V_TOTAL[DEFAULT_MODE] - 1);
            V_sync_pulse   <= PULSE_WIDTH'(V_SYNC[DEFAULT_MODE]);
            V_left_margin  <= MARGIN_WIDTH'(V_BP[DEFAULT_MODE]);
            V_right_margin <= MARGIN_WIDTH'(V_FP[DEFAULT_MODE]);
        end else begin
            Load_config <= apply_pend || apply_imm;
            if (apply_imm) begin
                Mode_active    <= idx;
                H_count_max    <= r_hmax;
                H_sync_pulse   <= r_hsync;
                H_left_margin  <= r_hbp;
                H_right_margin <= r_hfp;
                V_count_max    <= r_vmax;
                V_sync_pulse   <= r_vsync;
                V_left_margin  <= r_vbp;
                V_right_margin <= r_vfp;
            end else if (apply_pend) begin
                Mode_active    <= p_idx;
                H_count_max    <= p_hmax;
                H_sync_pulse   <= p_hsync;
                H_left_margin  <= p_hbp;
                H_right_margin <= p_hfp;
                V_count_max    <= p_vmax;
                V_sync_pulse   <= p_vsync;
                V_left_margin  <= p_vbp;
                V_right_margin <= p_vfp;
            end
        end
    end

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl: vector table plus hand sequences for
// custom-mode, boundary and reset-mid-change cases.
module tb_vga_mode_ctrl;
    import vga_mode_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fe  = 1'b0;

    always #5 clk = ~clk;

    vga_mode_ctrl_if #(.CONFIG_WIDTH(16)) bus ();

    logic        load, busy, err;
    logic [2:0]  mode;
    logic [7:0]  hsp, vsp;
    logic [10:0] hmax, vmax;
    logic [8:0]  hl, vl, hr, vr;

    vga_mode_ctrl dut (
        .Clk           (clk),
        .Rst           (rst),
        .cfg           (bus),
        .Frame_end     (fe),
        .Load_config   (load),
        .Cfg_busy      (busy),
        .Cfg_err       (err),
        .Mode_active   (mode),
        .H_sync_pulse  (hsp),
        .V_sync_pulse  (vsp),
        .H_count_max   (hmax),
        .V_count_max   (vmax),
        .H_left_margin (hl),
        .V_left_margin (vl),
        .H_right_margin(hr),
        .V_right_margin(vr)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] d;
        logic        f;
        logic        load;
        logic        busy;
        logic        err;
        int          mode;
        int          hmax;
        int          vsync;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a,
                         input logic [15:0] d, input logic f);
        bus.Valid = v;
        bus.Addr  = a;
        bus.Data  = d;
        fe        = f;
        tick();
        bus.Valid = 1'b0;
        fe        = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        drive(1'b1, a, d, 1'b0);
    endtask

    task automatic look(input string t, input logic l, input logic b,
                        input logic e, input int m, input int hm,
                        input int vs);
        chk({t, ".load"}, int'(load), int'(l));
        chk({t, ".busy"}, int'(busy), int'(b));
        chk({t, ".err"}, int'(err), int'(e));
        chk({t, ".mode"}, int'(mode), m);
        chk({t, ".hmax"}, int'(hmax), hm);
        chk({t, ".vsync"}, int'(vsp), vs);
    endtask

    function automatic vec_t mk(input logic v, input int a, input int d,
                                input logic f, input logic l,
                                input logic b, input logic e,
                                input int m, input int hm, input int vs);
        vec_t r;
        r.v = v; r.a = 16'(a); r.d = 16'(d); r.f = f;
        r.load = l; r.busy = b; r.err = e;
        r.mode = m; r.hmax = hm; r.vsync = vs;
        return r;
    endfunction

    initial begin
        bus.Valid = 1'b0;
        bus.Addr  = '0;
        bus.Data  = '0;

        // Table starts in PEND with mode 2 staged (set up below).
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 2, 1343, 6));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1343, 6));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2, 1343, 6));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 2, 1343, 6));
        tbl.push_back(mk(1, 0, 6, 0, 0, 1, 1, 2, 1343, 6));
        tbl.push_back(mk(1, 9, 0, 0, 0, 1, 0, 2, 1343, 6));
        tbl.push_back(mk(1, 0, 3, 0, 0, 1, 0, 2, 1343, 6));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 3, 1687, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 1687, 3));
        tbl.push_back(mk(1, 0, 5, 0, 0, 0, 1, 3, 1687, 3));
        tbl.push_back(mk(1, 0, 7, 0, 0, 0, 1, 3, 1687, 3));
        tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 3, 1687, 3));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 3, 1687, 3));
        tbl.push_back(mk(1, 0, 1, 1, 0, 1, 0, 3, 1687, 3));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 1055, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 1055, 4));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 799, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 799, 2));
        tbl.push_back(mk(1, 55, 3, 1, 0, 0, 0, 0, 799, 2));
`ifdef VGA_CFG_IMMEDIATE_EN
        tbl.push_back(mk(1, 0, 'h8002, 0, 1, 1, 0, 2, 1343, 6));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2, 1343, 6));
`else
        tbl.push_back(mk(1, 0, 'h8002, 0, 0, 1, 0, 0, 799, 2));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 2, 1343, 6));
`endif
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1343, 6));

        rst = 1'b1;
        tick();
        look("rst", 1, 0, 0, 0, 799, 2);
        chk("rst.vmax", int'(vmax), 524);
        chk("rst.hfp", int'(hr), 16);
        tick();
        rst = 1'b0;
        tick();
        look("post_rst", 0, 0, 0, 0, 799, 2);

        wr(16'(ADDR_MODE_SEL), 16'd2);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("wait%0d.busy", i), int'(busy), 1);
            chk($sformatf("wait%0d.hmax", i), int'(hmax), 799);
            chk($sformatf("wait%0d.load", i), int'(load), 0);
            tick();
        end

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].f);
            look($sformatf("vec%0d", i), tbl[i].load, tbl[i].busy,
                 tbl[i].err, tbl[i].mode, tbl[i].hmax, tbl[i].vsync);
        end

        // Custom mode: blanking too large, then fixed.
        wr(16'(ADDR_CUST_HMAX), 16'd99);
        wr(16'(ADDR_CUST_HSYNC), 16'd50);
        wr(16'(ADDR_CUST_HBP), 16'd30);
        wr(16'(ADDR_CUST_HFP), 16'd20);
        wr(16'(ADDR_MODE_SEL), 16'd4);
        chk("cust_bad.err", int'(err), 1);
        chk("cust_bad.busy", int'(busy), 0);
        chk("cust_bad.mode", int'(mode), 2);
        wr(16'(ADDR_ERR_CLR), 16'd0);
        chk("clr.err", int'(err), 0);
        wr(16'(ADDR_CUST_HFP), 16'd10);
        wr(16'(ADDR_MODE_SEL), 16'd4);
        chk("cust_ok.busy", int'(busy), 1);
        chk("cust_ok.err", int'(err), 0);
        wr(16'(ADDR_CUST_HFP), 16'd5);
        drive(1'b0, 16'd0, 16'd0, 1'b1);
        look("cust_apply", 1, 1, 0, 4, 99, 2);
        chk("cust_apply.hfp", int'(hr), 10);
        chk("cust_apply.hsync", int'(hsp), 50);
        chk("cust_apply.hbp", int'(hl), 30);
        chk("cust_apply.vmax", int'(vmax), 524);
        chk("cust_apply.vbp", int'(vl), 33);
        chk("cust_apply.vfp", int'(vr), 10);
        drive(1'b0, 16'd0, 16'd0, 1'b0);
        chk("cust_done.busy", int'(busy), 0);

        // Sum equal to count_max is rejected; one less is accepted.
        wr(16'(ADDR_CUST_HFP), 16'd19);
        wr(16'(ADDR_MODE_SEL), 16'd4);
        chk("cust_eq.err", int'(err), 1);
        chk("cust_eq.busy", int'(busy), 0);
        wr(16'(ADDR_ERR_CLR), 16'd0);
        wr(16'(ADDR_CUST_HFP), 16'd18);
        wr(16'(ADDR_MODE_SEL), 16'd4);
        chk("cust_lt.busy", int'(busy), 1);
        chk("cust_lt.err", int'(err), 0);
        drive(1'b0, 16'd0, 16'd0, 1'b1);
        chk("cust_lt.load", int'(load), 1);
        chk("cust_lt.hfp", int'(hr), 18);
        drive(1'b0, 16'd0, 16'd0, 1'b0);

        // Vertical sum check (2+33+10 >= 40).
        wr(16'(ADDR_CUST_VMAX), 16'd40);
        wr(16'(ADDR_MODE_SEL), 16'd4);
        chk("cust_v.err", int'(err), 1);
        chk("cust_v.busy", int'(busy), 0);

        // Reset while PEND discards the staged mode and custom values.
        wr(16'(ADDR_MODE_SEL), 16'd3);
        chk("pend3.busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        look("rst_pend", 1, 0, 0, 0, 799, 2);
        drive(1'b0, 16'd0, 16'd0, 1'b1);
        look("rst_fe", 0, 0, 0, 0, 799, 2);
        wr(16'(ADDR_MODE_SEL), 16'd4);
        chk("cust_rst.busy", int'(busy), 1);
        chk("cust_rst.err", int'(err), 0);
        drive(1'b0, 16'd0, 16'd0, 1'b1);
        look("cust_rst_apply", 1, 1, 0, 4, 799, 2);
        chk("cust_rst_apply.hfp", int'(hr), 16);
        chk("cust_rst_apply.vmax", int'(vmax), 524);
        drive(1'b0, 16'd0, 16'd0, 1'b0);
        look("end", 0, 0, 0, 4, 799, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
